// File: rtl/mult_pkg.sv
// Shared types for the multiplier request front end.
//   OP_W / PROD_W    : operand and product widths of mult_32bit_no_ops
//   dispatch_state_t : issue FSM states
//   req_op_t         : operand part of a queued request (the tag is appended
//                      by mult_dispatch, whose tag width is a parameter)
package mult_pkg;
  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} dispatch_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            sgn;
  } req_op_t;
endpackage

// File: rtl/mult_req_fifo.sv
// Synchronous request FIFO with a combinational head read.
//   clk, reset_n : clock, async active-low reset (pointers/count only)
//   push, din    : write an entry (caller never pushes when full)
//   pop, dout    : dout is the current head; pop advances it (never when empty)
//   count        : occupancy 0..DEPTH; full/empty are derived from it upstream
module mult_req_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Storage carries no reset; only entries counted as valid are ever read.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;

  assign dout = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mult_dispatch.sv
// Front end for the sequential multiplier: queues tagged requests, issues one
// at a time on start/done, and returns products in request order.
//   req_*             : valid/ready request port (operands, signedness, tag)
//   mul_*             : start pulse, operands and signed_mode to the multiplier;
//                       done/product back from it
//   rsp_*             : valid/ready response port (captured product + tag)
//   count             : FIFO occupancy
//   err_spurious_done : sticky, done rose while no operation was in flight
module mult_dispatch
  import mult_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter int  TAG_W = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_a,
  input  logic [OP_W-1:0]   req_b,
  input  logic              req_signed,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              mul_start,
  output logic              mul_signed_mode,
  output logic [OP_W-1:0]   mul_op_a,
  output logic [OP_W-1:0]   mul_op_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_product,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [PROD_W-1:0] rsp_product,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [CW-1:0]     count,
  output logic              err_spurious_done
);
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    req_op_t          op;
  } req_entry_t;

  req_entry_t      wr_entry, head;
  dispatch_state_t state;
  logic            done_q, done_rise, push, pop, fifo_empty;
  logic [TAG_W-1:0] tag_q;

  assign wr_entry.tag    = req_tag;
  assign wr_entry.op.a   = req_a;
  assign wr_entry.op.b   = req_b;
  assign wr_entry.op.sgn = req_signed;

  // No full-bypass: a pop in the same cycle does not open the port.
  assign req_ready  = (count != CW'(DEPTH));
  assign push       = req_valid && req_ready;
  assign fifo_empty = (count == '0);
  assign done_rise  = mul_done && !done_q;

  // Pops happen only on the way into ISSUE: from IDLE, or from HOLD as the
  // response is accepted so the next operation starts without an IDLE cycle.
  assign pop = !fifo_empty &&
               ((state == IDLE) || (state == HOLD && rsp_valid && rsp_ready));

  mult_req_fifo #(.DEPTH(DEPTH), .W($bits(req_entry_t))) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (wr_entry),
    .pop     (pop),
    .dout    (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      done_q            <= 1'b0;
      mul_start         <= 1'b0;
      mul_signed_mode   <= 1'b0;
      mul_op_a          <= '0;
      mul_op_b          <= '0;
      tag_q             <= '0;
      rsp_valid         <= 1'b0;
      rsp_product       <= '0;
      rsp_tag           <= '0;
      err_spurious_done <= 1'b0;
    end else begin
      done_q    <= mul_done;
      // Every pop enters ISSUE, so start is simply the registered pop.
      mul_start <= pop;
      // Operands move only on a pop; they stay put through WAIT and HOLD.
      if (pop) begin
        mul_op_a        <= head.op.a;
        mul_op_b        <= head.op.b;
        mul_signed_mode <= head.op.sgn;
        tag_q           <= head.tag;
      end
      if (done_rise && state != WAIT) err_spurious_done <= 1'b1;
      case (state)
        IDLE:  if (pop) state <= ISSUE;
        ISSUE: state <= WAIT;
        WAIT:
          if (done_rise) begin
            rsp_product <= mul_product;
            rsp_tag     <= tag_q;
            rsp_valid   <= 1'b1;
            state       <= HOLD;
          end
        HOLD:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? ISSUE : IDLE;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_dispatch.sv
// Bench for mult_dispatch: behavioural multiplier model on the start/done side,
// expected responses queued at request acceptance and checked on each handshake.
module tb_mult_dispatch;
  import mult_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  // Model: done rises LAT edges after it samples start; the DUT then needs one
  // edge to capture, one HOLD handshake edge, so starts are LAT+3 apart.
  localparam int LAT       = 3;
  localparam int START_GAP = LAT + 3;

  typedef struct {
    logic [63:0]      p;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid = 1'b0, req_ready;
  logic [31:0]       req_a = '0, req_b = '0;
  logic              req_signed = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic              mul_start, mul_signed_mode;
  logic [31:0]       mul_op_a, mul_op_b;
  logic              mul_done;
  logic [63:0]       mul_product;
  logic              rsp_valid, rsp_ready = 1'b1;
  logic [63:0]       rsp_product;
  logic [TAG_W-1:0]  rsp_tag;
  logic [CW-1:0]     count;
  logic              err_spurious_done;

  int   errors = 0, checks = 0, cyc = 0, rsp_cnt = 0;
  exp_t exp_q[$];
  int   start_q[$];
  logic start_sgn[$];

  // multiplier model controls
  logic mdl_done, spur = 1'b0, stall = 1'b0, busy;
  int   done_len = 1, cnt, hold;
  logic [63:0] mprod;

  assign mul_done = mdl_done | spur;

  always #5 clk = ~clk;

  mult_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk), .reset_n (reset_n),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .req_signed (req_signed), .req_tag (req_tag),
    .mul_start (mul_start), .mul_signed_mode (mul_signed_mode),
    .mul_op_a (mul_op_a), .mul_op_b (mul_op_b),
    .mul_done (mul_done), .mul_product (mul_product),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_product (rsp_product), .rsp_tag (rsp_tag),
    .count (count), .err_spurious_done (err_spurious_done)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (s) return 64'(sa * sb);
    return {32'd0, a} * {32'd0, b};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_done <= 1'b0; busy <= 1'b0; cnt <= 0; hold <= 0;
      mprod <= '0; mul_product <= '0;
    end else if (mul_start) begin
      busy <= 1'b1; cnt <= LAT; mdl_done <= 1'b0;
      mprod <= ref_mul(mul_op_a, mul_op_b, mul_signed_mode);
    end else if (busy) begin
      if (!stall) begin
        if (cnt > 1) cnt <= cnt - 1;
        else begin
          busy <= 1'b0; mdl_done <= 1'b1; mul_product <= mprod; hold <= done_len;
        end
      end
    end else if (mdl_done) begin
      if (hold > 1) hold <= hold - 1;
      else mdl_done <= 1'b0;
    end
  end

  // Scoreboard / monitor. Inputs change at posedge+1, so the negedge view is
  // exactly what the next posedge sees.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mul_start) begin
        start_q.push_back(cyc);
        start_sgn.push_back(mul_signed_mode);
      end
      if (reset_n && rsp_valid && rsp_ready) begin
        rsp_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got %h/%0d want none", rsp_product, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (rsp_product !== e.p || rsp_tag !== e.t) begin
            errors++;
            $display("FAIL rsp_data got %h/%0d want %h/%0d", rsp_product, rsp_tag, e.p, e.t);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d want finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [TAG_W-1:0] t, input logic [63:0] p);
    bit acc = 1'b0;
    exp_t e;
    req_valid = 1'b1; req_a = a; req_b = b; req_signed = s; req_tag = t;
    for (int i = 0; i < 100 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    e.p = p; e.t = t;
    if (acc) exp_q.push_back(e);
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_timeout tag=%0d got not accepted want accepted", t);
    end
  endtask

  task automatic wait_drain(output bit ok);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    ok = (exp_q.size() == 0);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    tick(); tick();
    checks++;
    if ({req_ready, rsp_valid, mul_start, mul_signed_mode, err_spurious_done} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got %b want 10000",
               {req_ready, rsp_valid, mul_start, mul_signed_mode, err_spurious_done});
    end
    checks++;
    if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if ({mul_op_a, mul_op_b, rsp_product, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %0d want zeros", mul_op_a, mul_op_b, rsp_product, rsp_tag);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    push_req(32'd10, 32'd20, 1'b0, 4'd3, 64'd200);   // accepted at edge E
    checks++;
    if (mul_start !== 1'b0 || count !== CW'(1)) begin
      errors++; $display("FAIL single_e0 got start=%b count=%0d want 0/1", mul_start, count);
    end
    tick();                                           // E+1: popped, start high
    checks++;
    if ({mul_start, mul_signed_mode, mul_op_a, mul_op_b} !== {1'b1, 1'b0, 32'hA, 32'h14}) begin
      errors++;
      $display("FAIL single_issue got start=%b sm=%b a=%h b=%h want 1/0/a/14",
               mul_start, mul_signed_mode, mul_op_a, mul_op_b);
    end
    tick();                                           // E+2: WAIT
    checks++;
    if (mul_start !== 1'b0) begin errors++; $display("FAIL single_pulse got %b want 0", mul_start); end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_drain pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_signed();
    bit ok;
    start_sgn.delete();
    push_req(32'hFFFF_FFF6, 32'd20, 1'b1, 4'd1, 64'hFFFF_FFFF_FFFF_FF38);
    push_req(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2, 64'h4000_0000_0000_0000);
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL signed_drain pending=%0d want 0", exp_q.size()); end
    checks++;
    if (start_sgn.size() != 2 || start_sgn[0] !== 1'b1 || start_sgn[1] !== 1'b1) begin
      errors++; $display("FAIL signed_mode starts=%0d want 2 with mode 1", start_sgn.size());
    end
  endtask

  task automatic test_full();
    bit ok, rdy;
    int st = -1, ac = -1;
    exp_t e;
    logic [31:0] a6 = 32'd7, b6 = 32'd9;
    stall = 1'b1;
    for (int i = 0; i < 5; i++)
      push_req(32'(i + 100), 32'(i + 3), 1'b0, TAG_W'(i + 4), ref_mul(32'(i + 100), 32'(i + 3), 1'b0));
    checks++;
    if (count !== CW'(DEPTH) || req_ready !== 1'b0) begin
      errors++; $display("FAIL full_state got count=%0d ready=%b want 4/0", count, req_ready);
    end
    req_valid = 1'b1; req_a = a6; req_b = b6; req_signed = 1'b0; req_tag = 4'd9;
    for (int i = 0; i < 3; i++) begin
      rdy = req_ready;
      tick();
      checks++;
      if (rdy !== 1'b0) begin errors++; $display("FAIL full_hold got ready=%b want 0", rdy); end
    end
    stall = 1'b0;
    for (int i = 0; i < 60 && ac < 0; i++) begin
      rdy = req_ready;
      tick();
      if (rdy) ac = i;
      if (mul_start && st < 0) st = i;
    end
    req_valid = 1'b0;
    if (ac >= 0) begin
      e.p = ref_mul(a6, b6, 1'b0); e.t = 4'd9;
      exp_q.push_back(e);
    end
    checks++;
    if (st < 0 || ac != st + 1) begin
      errors++; $display("FAIL full_accept got accept@%0d start@%0d want accept one after start", ac, st);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_drain pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [63:0] p;
    logic [TAG_W-1:0] t;
    rsp_ready = 1'b0;
    push_req(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 4'd11, 64'h0B00_EA4E_242D_2080);
    push_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd12, 64'hFFFF_FFFE_0000_0001);
    for (int i = 0; i < 50 && !rsp_valid; i++) tick();
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b want 1", rsp_valid); end
    p = rsp_product; t = rsp_tag;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({rsp_valid, mul_start, rsp_product, rsp_tag} !== {1'b1, 1'b0, p, t}) begin
        errors++;
        $display("FAIL bp_stable got v=%b st=%b %h/%0d want 1/0 %h/%0d",
                 rsp_valid, mul_start, rsp_product, rsp_tag, p, t);
      end
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (mul_start !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got start=%b valid=%b want 1/0", mul_start, rsp_valid);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_drain pending=%0d want 0", exp_q.size()); end
  endtask

  task automatic test_done_robust();
    bit ok;
    int rc0 = rsp_cnt;
    done_len = 5;
    push_req(32'd6, 32'd7, 1'b0, 4'd5, 64'd42);
    wait_drain(ok);
    for (int i = 0; i < 10; i++) tick();
    done_len = 1;
    checks++;
    if (!ok || rsp_cnt - rc0 != 1 || err_spurious_done !== 1'b0) begin
      errors++;
      $display("FAIL done_hold got rsps=%0d err=%b want 1/0", rsp_cnt - rc0, err_spurious_done);
    end
    spur = 1'b1;
    tick();
    spur = 1'b0;
    checks++;
    if (err_spurious_done !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL spurious got err=%b valid=%b want 1/0", err_spurious_done, rsp_valid);
    end
    tick(); tick();
    checks++;
    if (rsp_valid !== 1'b0 || err_spurious_done !== 1'b1) begin
      errors++; $display("FAIL spurious_after got valid=%b err=%b want 0/1", rsp_valid, err_spurious_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [31:0] a, b;
    logic s;
    start_q.delete();
    push_req(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd0, 64'd1);
    for (int i = 1; i < 6; i++) begin
      a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1));
      push_req(a, b, s, TAG_W'(i), ref_mul(a, b, s));
    end
    wait_drain(ok);
    checks++;
    if (!ok || start_q.size() != 6) begin
      errors++; $display("FAIL b2b_count got starts=%0d pending=%0d want 6/0", start_q.size(), exp_q.size());
    end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] != START_GAP) begin
        errors++; $display("FAIL b2b_gap got %0d want %0d", start_q[i] - start_q[i-1], START_GAP);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rc0;
    stall = 1'b1;
    push_req(32'd1, 32'd2, 1'b0, 4'd1, 64'd2);
    push_req(32'd3, 32'd4, 1'b0, 4'd2, 64'd12);
    push_req(32'd5, 32'd6, 1'b0, 4'd3, 64'd30);
    checks++;
    if (count !== CW'(2)) begin errors++; $display("FAIL mid_queued got %0d want 2", count); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({count, req_ready, rsp_valid, mul_start, err_spurious_done, mul_op_a} !== {CW'(0), 4'b1000, 32'd0}) begin
      errors++;
      $display("FAIL mid_async got count=%0d rdy=%b v=%b st=%b err=%b a=%h want 0/1/0/0/0/0",
               count, req_ready, rsp_valid, mul_start, err_spurious_done, mul_op_a);
    end
    exp_q.delete();
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    rc0 = rsp_cnt;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (rsp_cnt != rc0 || count !== '0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL mid_after got rsps=%0d count=%0d state=%0d want 0/0/IDLE", rsp_cnt - rc0, count, dut.state);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_signed();
    test_full();
    test_backpressure();
    test_done_robust();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
